// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: finds the bit offset at which the ADC frame lane reads as a
// clean 0xFF/0x00 alternation, barrel-shifts the data lane by that offset and
// assembles 16-bit samples (MSB byte first) with a one-cycle valid strobe.
module adc_frame_aligner #(
    parameter int LOCK_COUNT = 16,
    parameter int MISS_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din_data,
    input  logic [7:0]  din_frame,
    input  logic        realign,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        locked,
    output logic [2:0]  offset,
    output logic [7:0]  slip_wraps
);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] GOOD_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

    // Byte starting 'shift' bits after the MSB of the 16-bit window.
    function automatic logic [7:0] align_byte(input logic [15:0] window, input logic [2:0] shift);
        logic [15:0] shifted;
        shifted = window << shift;
        return shifted[15:8];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0]  prev_data_p0_q, prev_data_p0_d;
    logic [7:0]  prev_frame_p0_q, prev_frame_p0_d;
    logic [7:0]  ad_p1_q, ad_p1_d;
    logic [7:0]  af_p1_q, af_p1_d;
    logic [7:0]  ad_p2_q, ad_p2_d;
    logic [7:0]  af_p2_q, af_p2_d;

    state_t      state_q;
    logic        settle_cnt_q;
    logic [7:0]  good_cnt_q;
    logic [3:0]  miss_cnt_q;
    logic [2:0]  offset_q;
    logic [7:0]  slip_wraps_q;
    logic        locked_q;
    logic [15:0] sample_q;
    logic        sample_valid_q;

    logic        good_cmp;
    logic        emit;
    logic [2:0]  slip_offset;
    logic [7:0]  slip_wraps_next;

    // Next values for the byte window and the two aligned-byte stages.
    always_comb begin
        // Stage p0: previous byte of each lane, forming {prev, din}
        prev_data_p0_d  = din_data;
        prev_frame_p0_d = din_frame;
        // Stage p1: barrel-shifted bytes at the current offset
        ad_p1_d = align_byte({prev_data_p0_q, din_data}, offset_q);
        af_p1_d = align_byte({prev_frame_p0_q, din_frame}, offset_q);
        // Stage p2: one-cycle-delayed copy for pairwise compare and sample assembly
        ad_p2_d = ad_p1_q;
        af_p2_d = af_p1_q;
    end

    // Datapath pipeline registers, cleared by reset so no stale byte survives an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data_p0_q  <= 8'h00;
            prev_frame_p0_q <= 8'h00;
            ad_p1_q         <= 8'h00;
            af_p1_q         <= 8'h00;
            ad_p2_q         <= 8'h00;
            af_p2_q         <= 8'h00;
        end else begin
            prev_data_p0_q  <= prev_data_p0_d;
            prev_frame_p0_q <= prev_frame_p0_d;
            ad_p1_q         <= ad_p1_d;
            af_p1_q         <= af_p1_d;
            ad_p2_q         <= ad_p2_d;
            af_p2_q         <= af_p2_d;
        end
    end

    // Frame compare, emission condition and the offset/wrap values used on a slip.
    always_comb begin
        good_cmp = ((af_p1_q == 8'hFF) && (af_p2_q == 8'h00)) ||
                   ((af_p1_q == 8'h00) && (af_p2_q == 8'hFF));
        // The FF byte arrived first, so {ad_p2, ad_p1} is a complete MSB-first sample.
        emit = (state_q == LOCKED) && (af_p1_q == 8'h00) && (af_p2_q == 8'hFF) && !realign;
        slip_offset     = offset_q + 3'd1;
        slip_wraps_next = (offset_q == 3'd7) ? sat_inc8(slip_wraps_q) : slip_wraps_q;
    end

    // Alignment FSM with registered status and sample outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SETTLE;
            settle_cnt_q   <= 1'b0;
            good_cnt_q     <= 8'd0;
            miss_cnt_q     <= 4'd0;
            offset_q       <= 3'd0;
            slip_wraps_q   <= 8'd0;
            locked_q       <= 1'b0;
            sample_q       <= 16'h0000;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= emit;
            if (emit) begin
                sample_q <= {ad_p2_q, ad_p1_q};
            end
            if (realign) begin
                // Realign keeps the offset, even when it lands on a miss-limit unlock.
                state_q      <= SETTLE;
                settle_cnt_q <= 1'b0;
                locked_q     <= 1'b0;
            end else begin
                case (state_q)
                    SETTLE: begin
                        // Two cycles let a new offset reach both compare stages.
                        good_cnt_q <= 8'd0;
                        miss_cnt_q <= 4'd0;
                        if (settle_cnt_q) begin
                            state_q      <= SEARCH;
                            settle_cnt_q <= 1'b0;
                        end else begin
                            settle_cnt_q <= 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (good_cmp) begin
                            good_cnt_q <= good_cnt_q + 8'd1;
                            if (good_cnt_q == GOOD_LAST) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            offset_q     <= slip_offset;
                            slip_wraps_q <= slip_wraps_next;
                            state_q      <= SETTLE;
                            settle_cnt_q <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (good_cmp) begin
                            miss_cnt_q <= 4'd0;
                        end else if (miss_cnt_q == MISS_LAST) begin
                            offset_q     <= slip_offset;
                            slip_wraps_q <= slip_wraps_next;
                            locked_q     <= 1'b0;
                            state_q      <= SETTLE;
                            settle_cnt_q <= 1'b0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign locked       = locked_q;
    assign offset       = offset_q;
    assign slip_wraps   = slip_wraps_q;

endmodule
